// File: rtl/operand_fetch.sv
// Operand fetch: walks addresses 0..MEM_DEPTH-1 through two async-read memories and
// presents each captured pair on a valid/ready port. Optional stall counter: OPERAND_FETCH_STALL_CNT_EN.
module operand_fetch #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 8,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic [AW-1:0]        operand1_addr_o,
  output logic [AW-1:0]        operand2_addr_o,
  input  logic [MEM_WIDTH-1:0] operand1_i,
  input  logic [MEM_WIDTH-1:0] operand2_i,
  output logic                 pair_valid_o,
  input  logic                 pair_ready_i,
  output logic [MEM_WIDTH-1:0] operand1_o,
  output logic [MEM_WIDTH-1:0] operand2_o,
  output logic [AW-1:0]        pair_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t               state;
  logic [AW-1:0]        cnt_p0;
  logic [MEM_WIDTH-1:0] op1_p1;
  logic [MEM_WIDTH-1:0] op2_p1;
  logic [AW-1:0]        idx_p1;
  logic                 vld_p1;
  logic                 busy_q;
  logic                 done_q;
  logic                 capture;
  logic                 xfer;
  logic                 last;

  assign capture = (state == FETCH) && (!vld_p1 || pair_ready_i);
  assign xfer    = vld_p1 && pair_ready_i;
  assign last    = (cnt_p0 == AW'(MEM_DEPTH - 1));

  // p0: address counter drives both memories directly
  assign operand1_addr_o = cnt_p0;
  assign operand2_addr_o = cnt_p0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt_p0 <= '0;
      op1_p1 <= '0;
      op2_p1 <= '0;
      idx_p1 <= '0;
      vld_p1 <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt_p0 <= '0;
          if (start_i) begin
            state  <= FETCH;
            busy_q <= 1'b1;
          end
        end
        FETCH: begin
          // p1: capture only when the output slot is empty or being drained this cycle
          if (capture) begin
            op1_p1 <= operand1_i;
            op2_p1 <= operand2_i;
            idx_p1 <= cnt_p0;
            vld_p1 <= 1'b1;
            cnt_p0 <= cnt_p0 + AW'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            vld_p1 <= 1'b0;
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign operand1_o   = op1_p1;
  assign operand2_o   = op2_p1;
  assign pair_idx_o   = idx_p1;
  assign pair_valid_o = vld_p1;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Cleared at pass start, then held after the pass so software can read it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((state == IDLE) && start_i) begin
      stall_q <= '0;
    end else if (vld_p1 && !pair_ready_i) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: op1[i]=i, op2[i]=10+i, depth 8.
module tb_operand_fetch;

  localparam int W = 32;
  localparam int D = 8;
  localparam int AW = 3;
`ifdef OPERAND_FETCH_STALL_CNT_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] addr1, addr2;
  logic [W-1:0]  in1, in2;
  logic          valid;
  logic          ready;
  logic [W-1:0]  out1, out2;
  logic [AW-1:0] idx;
  logic          busy, done;
  logic [15:0]   stall;

  logic [W-1:0] mem1 [D];
  logic [W-1:0] mem2 [D];

  int checks = 0;
  int errors = 0;

  assign in1 = mem1[addr1];
  assign in2 = mem2[addr2];

  always #5 clk = ~clk;

  operand_fetch #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .operand1_addr_o(addr1), .operand2_addr_o(addr2),
    .operand1_i(in1), .operand2_i(in2),
    .pair_valid_o(valid), .pair_ready_i(ready),
    .operand1_o(out1), .operand2_o(out2), .pair_idx_o(idx),
    .busy_o(busy), .done_o(done), .stall_cnt_o(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input int i);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_idx"}, 32'(idx), 32'(i));
    check({tag, "_op1"}, out1, 32'(i));
    check({tag, "_op2"}, out2, 32'(10 + i));
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_idx"}, 32'(idx), 32'd0);
    check({tag, "_op1"}, out1, 32'd0);
    check({tag, "_op2"}, out2, 32'd0);
    check({tag, "_addr1"}, 32'(addr1), 32'd0);
    check({tag, "_addr2"}, 32'(addr2), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int exp_idx, dones, xfer7, r;
    for (int i = 0; i < D; i++) begin
      mem1[i] = W'(i);
      mem2[i] = W'(10 + i);
    end
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Plain pass, ready held high
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_c1_busy", 32'(busy), 32'd1);
    check("p1_c1_addr", 32'(addr1), 32'd0);
    check("p1_c1_valid", 32'(valid), 32'd0);
    for (int i = 0; i < D; i++) begin
      tick();
      check_pair("p1", i);
      check("p1_addr_eq", 32'(addr2), 32'(addr1));
    end
    tick();
    check("p1_done_c10", 32'(done), 32'd1);
    check("p1_valid_c10", 32'(valid), 32'd0);
    check("p1_busy_c10", 32'(busy), 32'd1);
    tick();
    check("p1_done_c11", 32'(done), 32'd0);
    check("p1_busy_c11", 32'(busy), 32'd0);
    check("p1_stall", 32'(stall), 32'd0);

    // Backpressure: ready low for 3 cycles with idx 2 presented
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pair("bp_pre", i);
    end
    ready = 1'b0;
    repeat (3) begin
      tick();
      check_pair("bp_hold", 2);
      check("bp_addr", 32'(addr1), 32'd3);
    end
    check("bp_stall", 32'(stall), 32'(3 * STALL_EN));
    ready = 1'b1;
    for (int i = 3; i < D; i++) begin
      tick();
      check_pair("bp_post", i);
    end
    tick();
    check("bp_done", 32'(done), 32'd1);
    tick();
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_stall_hold", 32'(stall), 32'(3 * STALL_EN));

    // Alternating ready
    start = 1'b1;
    tick();
    start = 1'b0;
    check("alt_stall_clear", 32'(stall), 32'd0);
    exp_idx = 0;
    dones = 0;
    xfer7 = -100;
    r = 1;
    for (int k = 0; k < 60 && !(busy == 1'b0 && dones > 0); k++) begin
      if (done) begin
        dones++;
        check("alt_done_cycle", 32'(k), 32'(xfer7 + 1));
      end
      if (valid) begin
        check("alt_idx", 32'(idx), 32'(exp_idx));
        check("alt_op1", out1, 32'(exp_idx));
        check("alt_op2", out2, 32'(10 + exp_idx));
      end
      ready = r[0];
      if (valid && ready) begin
        if (exp_idx == 7) xfer7 = k;
        exp_idx++;
      end
      r = 1 - r;
      tick();
    end
    check("alt_count", 32'(exp_idx), 32'd8);
    check("alt_dones", 32'(dones), 32'd1);
    check("alt_idle", 32'(busy), 32'd0);
    ready = 1'b1;

    // start ignored mid-pass and in the DONE cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      tick();
      check_pair("rs", i);
      if (i == 4) start = 1'b1;
      else start = 1'b0;
    end
    tick();
    check("rs_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_idle1", 32'(busy), 32'd0);
    check("rs_nodone1", 32'(done), 32'd0);
    tick();
    check("rs_idle2", 32'(busy), 32'd0);
    check("rs_valid2", 32'(valid), 32'd0);

    // Asynchronous reset mid-cycle with idx 5 presented
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_pair("ar_pre", i);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("ar_async");
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_c1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < D; i++) begin
      tick();
      check_pair("ar_post", i);
    end
    tick();
    check("ar_done", 32'(done), 32'd1);
    tick();

    // Final pair held in DRAIN for 5 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      tick();
      check_pair("fh_pre", i);
    end
    ready = 1'b0;
    repeat (5) begin
      tick();
      check_pair("fh_hold", 7);
      check("fh_busy", 32'(busy), 32'd1);
    end
    ready = 1'b1;
    tick();
    check("fh_done", 32'(done), 32'd1);
    check("fh_valid", 32'(valid), 32'd0);
    check("fh_stall", 32'(stall), 32'(5 * STALL_EN));
    tick();
    check("fh_done_off", 32'(done), 32'd0);
    check("fh_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Upstream feeder for `operation`. It sequences addresses 0..MEM_DEPTH-1 into the two operand memories and captures each operand pair. It presents each pair to the compute stage through a valid/ready handshake together with its element index, so that downstream result addressing and the DPI step/commit check stay aligned to memory order. One pass per `start_i` pulse; `done_o` pulses once the last pair is consumed.

## Interface
- `MEM_WIDTH`, 32, operand width in bits
- `MEM_DEPTH`, 8, elements per pass; power of two, ≥2; `AW = $clog2(MEM_DEPTH)`

- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `start_i` in 1: begin a pass. Sampled only in IDLE.
- `operand1_addr_o` out AW: read address into operand1 memory.
- `operand2_addr_o` out AW: read address into operand2 memory. Always equal to `operand1_addr_o`.
- `operand1_i` in MEM_WIDTH: asynchronous-read data at `operand1_addr_o`, same cycle.
- `operand2_i` in MEM_WIDTH: asynchronous-read data at `operand2_addr_o`, same cycle.
- `pair_valid_o` out 1: output pair valid.
- `pair_ready_i` in 1: downstream accepts the pair.
- `operand1_o`, `operand2_o` out MEM_WIDTH: registered operand pair.
- `pair_idx_o` out AW: element index of the presented pair.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse at end of pass.
- `stall_cnt_o` out 16: stall counter; see Configuration.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- **IDLE**
  - Address counter = 0; no capture.
  - `start_i` → FETCH.
- **FETCH**
  - A capture occurs when `!pair_valid_o || pair_ready_i`.
  - On capture:
    - `operand1_o`, `operand2_o` ← `operand1_i`, `operand2_i`.
    - `pair_idx_o` ← counter.
    - `pair_valid_o` ← 1.
  - Counter increments on each capture.
  - After capturing index MEM_DEPTH-1: counter wraps to 0 and state → DRAIN.
- **DRAIN**
  - Wait for handshake of the final pair.
  - On `pair_valid_o && pair_ready_i`: `pair_valid_o` ← 0, state → DONE.
- **DONE**
  - `done_o` = 1 for exactly this cycle, then → IDLE.
- **Handshake**
  - A transfer occurs on any cycle with `pair_valid_o && pair_ready_i`.
  - While `pair_valid_o && !pair_ready_i`: `operand*_o`, `pair_idx_o` and the counter hold stable; no capture.
  - `pair_valid_o` never drops without a transfer.
  - In FETCH, a transfer and a new capture in the same cycle are allowed (back-to-back).
  - A transfer without capture clears `pair_valid_o`; this happens only in DRAIN.
- **Boundary conditions**
  - `start_i` in any state other than IDLE is ignored; no restart and no counter disturbance.
  - `start_i` in the DONE cycle is ignored; a new pass needs `start_i` in IDLE.
  - `pair_ready_i` while `pair_valid_o` = 0 has no effect.
  - Reset mid-pass: all state returns to reset values immediately (asynchronous); the partial pass is abandoned with no `done_o`.
- **Widths:** counter is AW bits and wraps naturally modulo MEM_DEPTH. Memory data passes through unmodified.

## Timing
- Reset values:
  - state = IDLE
  - `operand1_addr_o` = `operand2_addr_o` = 0
  - `operand1_o` = `operand2_o` = 0
  - `pair_idx_o` = 0
  - `pair_valid_o` = 0, `busy_o` = 0, `done_o` = 0, `stall_cnt_o` = 0
- Latency:
  - `start_i` high in cycle 0 → FETCH in cycle 1, address 0 driven in cycle 1.
  - `pair_valid_o` high in cycle 2 with index 0.
- Throughput: one pair per cycle with `pair_ready_i` held high.
  - Indices 0..MEM_DEPTH-1 appear in cycles 2..MEM_DEPTH+1.
  - `done_o` pulses in cycle MEM_DEPTH+2 (cycle 10 for depth 8).
  - `busy_o` is high in cycles 1..MEM_DEPTH+2.
- Address outputs are combinational from the counter. Operand inputs must settle within the same cycle.

## Configuration
- `OPERAND_FETCH_STALL_CNT_EN`
  - **Defined:** `stall_cnt_o` counts cycles with `pair_valid_o && !pair_ready_i`.
    - Saturates at 0xFFFF.
    - Clears on the IDLE→FETCH transition and on reset.
    - Holds its value after the pass for readout.
  - **Undefined:** counter logic is omitted; `stall_cnt_o` is tied to 0.

## Test plan
- **Reset then start, ready=1, depth 8, memories op1[i]=i, op2[i]=10+i**
  - Pairs (0,10)..(7,17) with idx 0..7 in cycles 2..9.
  - `done_o` is a single pulse in cycle 10.
  - `busy_o` deasserts in cycle 11.
- **Backpressure: ready=0 for 3 cycles while idx 2 is valid**
  - idx 2 pair stays stable for all 3 cycles; address holds at 3.
  - No pairs are lost or duplicated.
  - `stall_cnt_o` = 3 with the macro defined, 0 without.
- **Alternating ready (1,0,1,0…)**
  - All 8 pairs delivered in order.
  - `done_o` exactly once, the cycle after the idx-7 transfer.
- **start_i pulsed again mid-pass at idx 4 and during the DONE cycle**
  - Both ignored: index sequence unbroken, single `done_o`, return to IDLE.
- **rst_ni asserted asynchronously mid-cycle while idx 5 is valid**
  - All outputs go to 0 immediately.
  - A fresh `start_i` restarts at idx 0.
- **Final pair held: ready=0 in DRAIN for 5 cycles**
  - `done_o` stays low.
  - idx 7 stays valid.
  - `done_o` pulses the cycle after ready rises.
